fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 16-bit core: owns the program counter, drives the
//  instruction-memory address and captures the returned word into the IF/ID register
//  for the decoder. Handles decoder back-pressure, taken-branch redirects from the
//  execute stage, and early resolution of unconditional jmp (opcode 3'b111) in fetch.
// PARAMETERS
//  RESET_PC    0    PC value loaded on reset
//  IMEM_DEPTH  512  instruction-memory words; PC wraps modulo this (power of 2)
//  ADDR_W      16   width of PC and address buses
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  imem_addr    out  ADDR_W  address to instruction memory (= pc, combinational)
//  imem_instr   in   16      instruction word, combinational read of imem_addr
//  redirect     in   1       taken branch from execute; flush and reload PC
//  redirect_pc  in   ADDR_W  branch target (masked modulo IMEM_DEPTH)
//  id_ready     in   1       decoder accepts id_instr this cycle
//  id_valid     out  1       IF/ID register holds a valid instruction
//  id_instr     out  16      captured instruction
//  id_pc        out  ADDR_W  address of id_instr
//  id_pc_plus1  out  ADDR_W  (id_pc+1) mod IMEM_DEPTH, for beq target math
//  fetch_count  out  16      accepted fetches since reset, saturating
// BEHAVIOUR
//  - Reset (sync, highest priority): pc=RESET_PC; id_valid=0; id_instr=0; id_pc=0;
//    id_pc_plus1=0; fetch_count=0. Reset mid-stall or mid-redirect discards everything.
//  - imem_addr = pc every cycle; memory read treated as zero-latency.
//  - slot_free = !id_valid | id_ready. Per-edge priority: rst > redirect > slot_free > hold.
//  - redirect=1: pc <= redirect_pc mod IMEM_DEPTH; id_valid <= 0; id_instr <= 0;
//    fetch_count unchanged. Overrides stall and early jmp in same cycle. Word at
//    imem_addr that cycle is dropped.
//  - Capture (slot_free, no redirect): id_instr <= imem_instr; id_pc <= pc;
//    id_pc_plus1 <= pc+1 mod IMEM_DEPTH; id_valid <= 1; fetch_count += 1 (hold at FFFF);
//    next pc = imem_instr[15:13]==3'b111 ? {imem_instr[12:0]} mod IMEM_DEPTH
//                                        : (pc+1) mod IMEM_DEPTH.
//    Captured jmp is still passed to decode (decode treats it as a no-op).
//  - Hold (!slot_free, no redirect): pc, id_* and fetch_count unchanged; id_valid stays 1.
//  - Throughput 1 instr/cycle with id_ready=1; latency imem_addr -> id_instr one edge.
//  - Redirect penalty: one bubble (id_valid=0 one cycle), then target word captured.
//  - Wrap: pc=IMEM_DEPTH-1 advances to 0; jmp/redirect targets >= IMEM_DEPTH masked.
//  - No X on outputs after reset; redirect_pc ignored when redirect=0.
// TESTING (memory model: Mem[i]=i unless stated; id_ready=1 unless stated)
//  1 rst 2 cycles, release -> edges 1..3: id_instr=0,1,2; id_pc=0,1,2;
//    id_pc_plus1=1,2,3; fetch_count=3; imem_addr=3.
//  2 id_valid=1, id_instr=5, id_ready=0 for 3 cycles -> id_instr=5, imem_addr=6,
//    fetch_count frozen; id_ready=1 -> next edge id_instr=6.
//  3 redirect=1, redirect_pc=17 while stalled -> next edge id_valid=0, imem_addr=17;
//    following edge id_instr=17, id_pc=17, id_valid=1.
//  4 Mem[12]=16'hE009 (jmp 9), run through 12 -> after capturing 12, imem_addr=9,
//    next id_pc=9 (no bubble); same cycle with redirect to 4 -> imem_addr=4.
//  5 redirect_pc=511, then free-run -> id_pc 511 then 0; redirect_pc=16'h0205 -> pc=5.
//  6 rst asserted during stall with id_valid=1 -> next edge all outputs at reset values,
//    imem_addr=RESET_PC; fetch_count saturation: force 16'hFFFE, 3 captures -> FFFF.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// fills the IF/ID register, with decoder back-pressure, branch redirect and early jmp.
module fetch_stage #(
   parameter int RESET_PC   = 0,
   parameter int IMEM_DEPTH = 512,
   parameter int ADDR_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_instr,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              id_ready,
   output logic              id_valid,
   output logic [15:0]       id_instr,
   output logic [ADDR_W-1:0] id_pc,
   output logic [ADDR_W-1:0] id_pc_plus1,
   output logic [15:0]       fetch_count
);

   localparam logic [ADDR_W-1:0] PC_MASK  = ADDR_W'(IMEM_DEPTH - 1);
   localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
   localparam logic [2:0]        OP_JMP   = 3'b111;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              id_valid_q, id_valid_d;
   logic [15:0]       id_instr_q, id_instr_d;
   logic [ADDR_W-1:0] id_pc_q, id_pc_d;
   logic [ADDR_W-1:0] id_pc_plus1_q, id_pc_plus1_d;
   logic [15:0]       fetch_count_q, fetch_count_d;

   logic              slot_free;
   logic              is_jmp;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] jmp_target;

   assign slot_free  = !id_valid_q || id_ready;
   assign is_jmp     = (imem_instr[15:13] == OP_JMP);
   assign pc_inc     = (pc_q + ADDR_W'(1)) & PC_MASK;
   assign jmp_target = ADDR_W'(imem_instr[12:0]) & PC_MASK;

   always_comb begin
      pc_d          = pc_q;
      id_valid_d    = id_valid_q;
      id_instr_d    = id_instr_q;
      id_pc_d       = id_pc_q;
      id_pc_plus1_d = id_pc_plus1_q;
      fetch_count_d = fetch_count_q;

      if (redirect) begin
         // The word currently at imem_addr is on the wrong path and is dropped.
         pc_d       = redirect_pc & PC_MASK;
         id_valid_d = 1'b0;
         id_instr_d = 16'h0000;
      end else if (slot_free) begin
         id_instr_d    = imem_instr;
         id_pc_d       = pc_q;
         id_pc_plus1_d = pc_inc;
         id_valid_d    = 1'b1;
         if (fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
         end
         // jmp resolves here so it costs no bubble; decode still sees it as a no-op.
         pc_d = is_jmp ? jmp_target : pc_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= PC_RESET;
         id_valid_q    <= 1'b0;
         id_instr_q    <= 16'h0000;
         id_pc_q       <= '0;
         id_pc_plus1_q <= '0;
         fetch_count_q <= 16'h0000;
      end else begin
         pc_q          <= pc_d;
         id_valid_q    <= id_valid_d;
         id_instr_q    <= id_instr_d;
         id_pc_q       <= id_pc_d;
         id_pc_plus1_q <= id_pc_plus1_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign id_valid    = id_valid_q;
   assign id_instr    = id_instr_q;
   assign id_pc       = id_pc_q;
   assign id_pc_plus1 = id_pc_plus1_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: zero-latency memory model (Mem[i]=i unless patched) and a
// queue of expected IF/ID contents, pushed when a fetch is set up and popped on capture.
module tb_fetch_stage;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
      logic [15:0] pc1;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] imem_addr;
   logic [15:0] imem_instr;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        id_ready = 1'b1;
   logic        id_valid;
   logic [15:0] id_instr;
   logic [15:0] id_pc;
   logic [15:0] id_pc_plus1;
   logic [15:0] fetch_count;

   logic [15:0] mem [512];
   exp_t        sb [$];
   exp_t        e;
   int          passed = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_addr[8:0]];

   fetch_stage #(.RESET_PC(0), .IMEM_DEPTH(512), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
      .id_pc_plus1(id_pc_plus1), .fetch_count(fetch_count)
   );

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input int a);
      exp_t x;
      x.instr = mem[a];
      x.pc    = 16'(a);
      x.pc1   = 16'((a + 1) % 512);
      sb.push_back(x);
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({id_valid, id_instr, id_pc, id_pc_plus1, fetch_count, imem_addr} !== {1'b0, 80'h0}) begin
         $display("FAIL reset_state: got v=%0b i=%h pc=%h p1=%h cnt=%h addr=%h want all zero",
                  id_valid, id_instr, id_pc, id_pc_plus1, fetch_count, imem_addr);
      end else passed++;
      rst = 1'b0;
   endtask

   task automatic test_sequential;
      push(0); push(1); push(2);
      repeat (3) begin
         tick();
         e = sb.pop_front();
         $display("capture pc=%0d instr=%h", id_pc, id_instr);
         total++;
         if (!id_valid || {id_instr, id_pc, id_pc_plus1} !== e) begin
            $display("FAIL seq_capture: got v=%0b %h/%h/%h want %h/%h/%h", id_valid,
                     id_instr, id_pc, id_pc_plus1, e.instr, e.pc, e.pc1);
         end else passed++;
      end
      total++;
      if (fetch_count !== 16'd3 || imem_addr !== 16'd3) begin
         $display("FAIL seq_count_addr: got cnt=%0d addr=%0d want 3 3", fetch_count, imem_addr);
      end else passed++;
   endtask

   task automatic test_stall;
      push(3); push(4); push(5);
      repeat (3) begin
         tick();
         e = sb.pop_front();
         $display("capture pc=%0d instr=%h", id_pc, id_instr);
         total++;
         if (!id_valid || {id_instr, id_pc, id_pc_plus1} !== e) begin
            $display("FAIL stall_prefill: got v=%0b %h/%h/%h want %h/%h/%h", id_valid,
                     id_instr, id_pc, id_pc_plus1, e.instr, e.pc, e.pc1);
         end else passed++;
      end
      id_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (!id_valid || id_instr !== 16'd5 || imem_addr !== 16'd6 || fetch_count !== 16'd6) begin
            $display("FAIL stall_hold: cycle %0d got v=%0b i=%0d addr=%0d cnt=%0d want 1 5 6 6",
                     c, id_valid, id_instr, imem_addr, fetch_count);
         end else passed++;
      end
      id_ready = 1'b1;
      push(6);
      tick();
      e = sb.pop_front();
      $display("capture pc=%0d instr=%h", id_pc, id_instr);
      total++;
      if (!id_valid || {id_instr, id_pc, id_pc_plus1} !== e || fetch_count !== 16'd7) begin
         $display("FAIL stall_release: got v=%0b %h/%h/%h cnt=%0d want %h/%h/%h cnt=7", id_valid,
                  id_instr, id_pc, id_pc_plus1, fetch_count, e.instr, e.pc, e.pc1);
      end else passed++;
   endtask

   task automatic test_redirect;
      id_ready = 1'b0;
      tick();
      redirect = 1'b1;
      redirect_pc = 16'd17;
      tick();
      total++;
      if (id_valid !== 1'b0 || id_instr !== 16'h0 || imem_addr !== 16'd17 || fetch_count !== 16'd7) begin
         $display("FAIL redirect_bubble: got v=%0b i=%h addr=%0d cnt=%0d want 0 0 17 7",
                  id_valid, id_instr, imem_addr, fetch_count);
      end else passed++;
      redirect = 1'b0;
      redirect_pc = 16'h0033;
      id_ready = 1'b1;
      push(17);
      tick();
      e = sb.pop_front();
      $display("capture pc=%0d instr=%h", id_pc, id_instr);
      total++;
      if (!id_valid || {id_instr, id_pc, id_pc_plus1} !== e || fetch_count !== 16'd8) begin
         $display("FAIL redirect_target: got v=%0b %h/%h/%h cnt=%0d want %h/%h/%h cnt=8", id_valid,
                  id_instr, id_pc, id_pc_plus1, fetch_count, e.instr, e.pc, e.pc1);
      end else passed++;
   endtask

   task automatic test_jmp;
      mem[12] = 16'hE009;
      redirect = 1'b1;
      redirect_pc = 16'd10;
      tick();
      redirect = 1'b0;
      push(10); push(11); push(12); push(9); push(10); push(11);
      for (int c = 0; c < 6; c++) begin
         tick();
         e = sb.pop_front();
         $display("capture pc=%0d instr=%h", id_pc, id_instr);
         total++;
         if (!id_valid || {id_instr, id_pc, id_pc_plus1} !== e) begin
            $display("FAIL jmp_flow: step %0d got v=%0b %h/%h/%h want %h/%h/%h", c, id_valid,
                     id_instr, id_pc, id_pc_plus1, e.instr, e.pc, e.pc1);
         end else passed++;
         if (c == 2) begin
            total++;
            if (imem_addr !== 16'd9) begin
               $display("FAIL jmp_target: got addr=%0d want 9", imem_addr);
            end else passed++;
         end
      end
      // pc is at 12 (the jmp) again; redirect in the same cycle must win
      redirect = 1'b1;
      redirect_pc = 16'd4;
      tick();
      total++;
      if (imem_addr !== 16'd4 || id_valid !== 1'b0) begin
         $display("FAIL jmp_vs_redirect: got addr=%0d v=%0b want 4 0", imem_addr, id_valid);
      end else passed++;
      redirect = 1'b0;
      push(4);
      tick();
      e = sb.pop_front();
      $display("capture pc=%0d instr=%h", id_pc, id_instr);
      total++;
      if (!id_valid || {id_instr, id_pc, id_pc_plus1} !== e || fetch_count !== 16'd15) begin
         $display("FAIL jmp_after_redirect: got v=%0b %h/%h/%h cnt=%0d want %h/%h/%h cnt=15",
                  id_valid, id_instr, id_pc, id_pc_plus1, fetch_count, e.instr, e.pc, e.pc1);
      end else passed++;
   endtask

   task automatic test_wrap;
      mem[6] = 16'hE203;
      redirect = 1'b1;
      redirect_pc = 16'd511;
      tick();
      redirect = 1'b0;
      push(511); push(0);
      repeat (2) begin
         tick();
         e = sb.pop_front();
         $display("capture pc=%0d instr=%h", id_pc, id_instr);
         total++;
         if (!id_valid || {id_instr, id_pc, id_pc_plus1} !== e) begin
            $display("FAIL wrap_flow: got v=%0b %h/%h/%h want %h/%h/%h", id_valid,
                     id_instr, id_pc, id_pc_plus1, e.instr, e.pc, e.pc1);
         end else passed++;
      end
      redirect = 1'b1;
      redirect_pc = 16'h0205;
      tick();
      total++;
      if (imem_addr !== 16'd5) begin
         $display("FAIL wrap_redirect_mask: got addr=%0d want 5", imem_addr);
      end else passed++;
      redirect = 1'b0;
      push(5); push(6);
      repeat (2) begin
         tick();
         e = sb.pop_front();
         $display("capture pc=%0d instr=%h", id_pc, id_instr);
         total++;
         if (!id_valid || {id_instr, id_pc, id_pc_plus1} !== e) begin
            $display("FAIL wrap_masked_flow: got v=%0b %h/%h/%h want %h/%h/%h", id_valid,
                     id_instr, id_pc, id_pc_plus1, e.instr, e.pc, e.pc1);
         end else passed++;
      end
      total++;
      if (imem_addr !== 16'd3 || fetch_count !== 16'd19) begin
         $display("FAIL wrap_jmp_mask: got addr=%0d cnt=%0d want 3 19", imem_addr, fetch_count);
      end else passed++;
   endtask

   task automatic test_reset_mid_stall;
      id_ready = 1'b0;
      tick();
      rst = 1'b1;
      redirect = 1'b1;
      redirect_pc = 16'd40;
      tick();
      total++;
      if ({id_valid, id_instr, id_pc, id_pc_plus1, fetch_count, imem_addr} !== {1'b0, 80'h0}) begin
         $display("FAIL reset_mid_stall: got v=%0b i=%h pc=%h p1=%h cnt=%h addr=%h want all zero",
                  id_valid, id_instr, id_pc, id_pc_plus1, fetch_count, imem_addr);
      end else passed++;
      rst = 1'b0;
      redirect = 1'b0;
      id_ready = 1'b1;
      push(0);
      tick();
      e = sb.pop_front();
      $display("capture pc=%0d instr=%h", id_pc, id_instr);
      total++;
      if (!id_valid || {id_instr, id_pc, id_pc_plus1} !== e || fetch_count !== 16'd1) begin
         $display("FAIL reset_restart: got v=%0b %h/%h/%h cnt=%0d want %h/%h/%h cnt=1", id_valid,
                  id_instr, id_pc, id_pc_plus1, fetch_count, e.instr, e.pc, e.pc1);
      end else passed++;
   endtask

   task automatic test_saturation;
      force dut.fetch_count_q = 16'hFFFE;
      #1;
      release dut.fetch_count_q;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (fetch_count !== 16'hFFFF) begin
            $display("FAIL count_saturate: capture %0d got %h want FFFF", c, fetch_count);
         end else passed++;
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 16'(i);
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_jmp();
      test_wrap();
      test_reset_mid_stall();
      test_saturation();
      total++;
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
      end else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
